fp_to_twoc_seq: RTL and testbench

//  Sequential decoder from the lab's compact floating-point format
//  {S, E[2:0], F[3:0]} back to 12-bit two's complement: D = (-1)^S * F * 2^E.
//  It is the return path of the twoc -> sign-magnitude -> FP encoder chain.
//  It sits between the FP register/display logic and any consumer needing an

---
 rtl/fp_to_twoc_seq_pkg.sv | 16 +
 rtl/fp_to_twoc_seq.sv | 93 +++++++++
 tb/tb_fp_to_twoc_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_to_twoc_seq_pkg.sv
// Shared definitions for the compact FP {S, E, F} <-> two's-complement converters:
// default field widths and the converter FSM state encoding.
package fp_to_twoc_seq_pkg;

    localparam int unsigned DEF_EXP_W  = 3;
    localparam int unsigned DEF_MANT_W = 4;
    localparam int unsigned DEF_OUT_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_NEG   = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

endpackage

// File: rtl/fp_to_twoc_seq.sv
// Sequential decoder: compact FP {S, E, F} to OUT_W-bit two's complement,
// D = (-1)^S * F * 2^E, one shift per clock, ready/valid on both sides.
module fp_to_twoc_seq
    import fp_to_twoc_seq_pkg::*;
#(
    parameter int unsigned EXP_W  = DEF_EXP_W,
    parameter int unsigned MANT_W = DEF_MANT_W,
    parameter int unsigned OUT_W  = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              S,
    input  logic [EXP_W-1:0]  E,
    input  logic [MANT_W-1:0] F,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  D
);

    localparam int unsigned MIN_OUT_W = MANT_W + (32'd1 << EXP_W);

    // Largest magnitude must fit without touching the sign bit.
    if (OUT_W < MIN_OUT_W) begin : g_width_check
        $error("fp_to_twoc_seq: OUT_W too small for EXP_W/MANT_W");
    end

    conv_state_e        state_q, state_d;
    logic [OUT_W-1:0]   mag_q,   mag_d;
    logic [EXP_W-1:0]   cnt_q,   cnt_d;
    logic               sgn_q,   sgn_d;
    logic [OUT_W-1:0]   d_q,     d_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        d_d     = d_q;
        unique case (state_q)
            ST_IDLE: begin
                // Inputs are captured only here; later changes cannot reach D.
                if (in_valid) begin
                    mag_d   = OUT_W'(F);
                    cnt_d   = E;
                    sgn_d   = S;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - EXP_W'(1);
                end else begin
                    state_d = ST_NEG;
                end
            end
            ST_NEG: begin
                // Negating a zero magnitude yields zero, so -0 never appears.
                d_d     = sgn_q ? (~mag_q + OUT_W'(1)) : mag_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign D         = d_q;

endmodule

// File: tb/tb_fp_to_twoc_seq.sv
// Directed self-checking bench for fp_to_twoc_seq: reset, latency, sign/zero
// corners, output backpressure, mid-conversion reset and a full code sweep.
module tb_fp_to_twoc_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] D;

    int checks = 0;
    int errors = 0;

    fp_to_twoc_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a code, wait for in_ready, complete the accept edge, then scramble inputs.
    task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f, output bit ok);
        S = s; E = e; F = f; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        S = ~s; E = ~e; F = ~f;
    endtask

    // Edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int edges, output bit ok);
        edges = 0;
        while (edges < 30 && !out_valid) begin
            tick();
            edges++;
        end
        ok = out_valid;
    endtask

    function automatic logic [11:0] ref_model(input logic s, input logic [2:0] e, input logic [3:0] f);
        int m;
        m = int'(f) << e;
        if (s) m = -m;
        return 12'(m);
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S = 1'b0; E = '0; F = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (D !== 12'h000) begin errors++; $display("FAIL reset_D got=%h exp=000", D); end
    endtask

    task automatic test_small_positive;
        bit ok; int edges;
        out_ready = 1'b1;
        send(1'b0, 3'b000, 4'b0101, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pos_accept got=timeout exp=accept"); end
        wait_valid(edges, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pos_valid got=timeout exp=out_valid"); end
        // out_valid at the 3rd edge counting the accept edge
        checks++; if (edges + 1 !== 3) begin errors++; $display("FAIL pos_latency got=%0d exp=3", edges + 1); end
        checks++; if (D !== 12'h005) begin errors++; $display("FAIL pos_D got=%h exp=005", D); end
        tick();
    endtask

    task automatic test_saturated;
        bit ok; int edges; bit rdy_seen;
        out_ready = 1'b1;
        send(1'b1, 3'b111, 4'b1111, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_accept got=timeout exp=accept"); end
        edges = 0; rdy_seen = 1'b0;
        while (edges < 30 && !out_valid) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            edges++;
        end
        if (in_ready) rdy_seen = 1'b1;
        checks++; if (!out_valid) begin errors++; $display("FAIL sat_valid got=timeout exp=out_valid"); end
        checks++; if (edges + 1 !== 10) begin errors++; $display("FAIL sat_latency got=%0d exp=10", edges + 1); end
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL sat_in_ready_busy got=%b exp=0", rdy_seen); end
        checks++; if (D !== 12'h880) begin errors++; $display("FAIL sat_D got=%h exp=880", D); end
        tick();
    endtask

    task automatic test_neg_zero;
        bit ok; int edges;
        out_ready = 1'b1;
        send(1'b1, 3'b011, 4'b0000, ok);
        wait_valid(edges, ok);
        checks++; if (!ok) begin errors++; $display("FAIL negzero_valid got=timeout exp=out_valid"); end
        checks++; if (D !== 12'h000) begin errors++; $display("FAIL negzero_D got=%h exp=000", D); end
        tick();
    endtask

    task automatic test_backpressure;
        bit ok; int edges; bit held;
        out_ready = 1'b0;
        send(1'b1, 3'b010, 4'b0011, ok);
        wait_valid(edges, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_valid got=timeout exp=out_valid"); end
        // -(3 * 2^2) = -12
        checks++; if (D !== 12'hFF4) begin errors++; $display("FAIL bp_D got=%h exp=ff4", D); end
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || D !== 12'hFF4 || in_ready !== 1'b0) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL bp_hold got=%b exp=1 (D=%h ov=%b)", held, D, out_valid); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_ov got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ir got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid_shift;
        bit ok; int edges;
        out_ready = 1'b1;
        send(1'b0, 3'b110, 4'b0001, ok);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (D !== 12'h000) begin errors++; $display("FAIL rstmid_D got=%h exp=000", D); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        send(1'b0, 3'b001, 4'b0001, ok);
        wait_valid(edges, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_next_valid got=timeout exp=out_valid"); end
        checks++; if (D !== 12'h002) begin errors++; $display("FAIL rstmid_next_D got=%h exp=002", D); end
        tick();
    endtask

    task automatic test_back_to_back;
        bit ok; int edges; logic [11:0] exp_d; logic s; logic [2:0] e; logic [3:0] f;
        int bad;
        bad = 0;
        out_ready = 1'b1;
        for (int code = 0; code < 256; code++) begin
            s = code[7]; e = code[6:4]; f = code[3:0];
            exp_d = ref_model(s, e, f);
            send(s, e, f, ok);
            if (!ok) begin
                errors++; checks++;
                $display("FAIL sweep_accept code=%02h got=timeout exp=accept", code);
                break;
            end
            edges = 0;
            while (edges < 30 && !out_valid) begin
                if (in_ready && out_valid) bad++;
                tick();
                edges++;
            end
            if (in_ready && out_valid) bad++;
            checks++;
            if (!out_valid || D !== exp_d || edges !== int'(e) + 2) begin
                errors++;
                $display("FAIL sweep code=%02h got D=%h lat=%0d ov=%b exp D=%h lat=%0d",
                         code, D, edges + 1, out_valid, exp_d, int'(e) + 3);
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL sweep_ready_valid_overlap got=%0d exp=0", bad); end
        tick();
    endtask

    initial begin
        test_reset();
        test_small_positive();
        test_saturated();
        test_neg_zero();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
